// File: rtl/goal_score_tracker_if.sv
// Per-frame geometry inputs and score/HUD outputs of goal_score_tracker.
// No handshake: every signal is a level sampled or updated once per frame_clk edge.
interface goal_score_tracker_if;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic [9:0] GoalLX;
    logic [9:0] GoalLY;
    logic [9:0] GoalLSX;
    logic [9:0] GoalLSY;
    logic [9:0] GoalRX;
    logic [9:0] GoalRY;
    logic [9:0] GoalRSX;
    logic [9:0] GoalRSY;
    logic [3:0] ScoreL;
    logic [3:0] ScoreR;
    logic       GoalFlash;
    logic       RoundReset;
    logic       GameOver;
    logic       Winner;

    modport master (
        output BallX, BallY, BallS,
        output GoalLX, GoalLY, GoalLSX, GoalLSY,
        output GoalRX, GoalRY, GoalRSX, GoalRSY,
        input  ScoreL, ScoreR, GoalFlash, RoundReset, GameOver, Winner
    );

    modport slave (
        input  BallX, BallY, BallS,
        input  GoalLX, GoalLY, GoalLSX, GoalLSY,
        input  GoalRX, GoalRY, GoalRSX, GoalRSY,
        output ScoreL, ScoreR, GoalFlash, RoundReset, GameOver, Winner
    );
endinterface

// File: rtl/goal_score_tracker.sv
// Goal detection with frame debounce, score keeping, celebration hold,
// round-reset pulse and sticky game-over for a two-goal ball game.
module goal_score_tracker #(
    parameter int DEBOUNCE     = 3,
    parameter int CELEB_FRAMES = 120,
    parameter int WIN_SCORE    = 5
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 Pause,
    goal_score_tracker_if.slave  bus,
    output logic [1:0]           dbg_state_o,
    output logic [3:0]           dbg_cnt_o
);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        CONFIRM   = 2'd1,
        CELEBRATE = 2'd2,
        GAME_OVER = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] celeb_q, celeb_d;
    logic       side_q, side_d;       // 0 = ball in left goal, 1 = right goal
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       flash_q, flash_d;
    logic       rr_q, rr_d;
    logic       go_q, go_d;
    logic       win_q, win_d;

    logic [10:0] b_x, b_y, b_s;
    logic [10:0] ball_left, ball_right, ball_top, ball_bot;
    logic [10:0] gl_top, gr_top;
    logic        in_l, in_r, in_any, hit_side;
    logic        award, award_side, win_reached;

    always_comb begin
        b_x        = {1'b0, bus.BallX};
        b_y        = {1'b0, bus.BallY};
        b_s        = {1'b0, bus.BallS};
        ball_right = b_x + b_s;
        ball_bot   = b_y + b_s;
        ball_left  = (b_x >= b_s) ? (b_x - b_s) : 11'd0;
        ball_top   = (b_y >= b_s) ? (b_y - b_s) : 11'd0;
        gl_top     = {1'b0, bus.GoalLY} - {1'b0, bus.GoalLSY};
        gr_top     = {1'b0, bus.GoalRY} - {1'b0, bus.GoalRSY};
        in_l       = (ball_right < ({1'b0, bus.GoalLX} + {1'b0, bus.GoalLSX}))
                     && (ball_top >= gl_top) && (ball_bot <= {1'b0, bus.GoalLY});
        in_r       = (ball_left >= {1'b0, bus.GoalRX})
                     && (ball_top >= gr_top) && (ball_bot <= {1'b0, bus.GoalRY});
        in_any     = in_l | in_r;
        hit_side   = ~in_l;           // left goal takes precedence when both hit
    end

    assign win_reached = (score_l_q == 4'(WIN_SCORE)) || (score_r_q == 4'(WIN_SCORE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        celeb_d    = celeb_q;
        side_d     = side_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        flash_d    = flash_q;
        rr_d       = 1'b0;
        go_d       = go_q;
        win_d      = win_q;
        award      = 1'b0;
        award_side = side_q;

        case (state_q)
            PLAY: begin
                if (in_any) begin
                    side_d = hit_side;
                    if (DEBOUNCE == 1) begin
                        award      = 1'b1;
                        award_side = hit_side;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (in_any && (hit_side == side_q)) begin
                    if (cnt_q == 4'(DEBOUNCE - 1)) award = 1'b1;
                    else                           cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = PLAY;
                end
            end
            CELEBRATE: begin
                if (celeb_q == 8'(CELEB_FRAMES - 1)) begin
                    flash_d = 1'b0;
                    if (win_reached) begin
                        go_d    = 1'b1;
                        win_d   = (score_r_q == 4'(WIN_SCORE));
                        state_d = GAME_OVER;
                    end else begin
                        rr_d    = 1'b1;
                        state_d = PLAY;
                    end
                end else begin
                    celeb_d = celeb_q + 8'd1;
                end
            end
            GAME_OVER: begin
                state_d = GAME_OVER;
            end
            default: state_d = PLAY;
        endcase

        // A ball in the left goal scores for the right player and vice versa.
        if (award) begin
            if (!award_side) score_r_d = (score_r_q == 4'd15) ? 4'd15 : score_r_q + 4'd1;
            else             score_l_d = (score_l_q == 4'd15) ? 4'd15 : score_l_q + 4'd1;
            cnt_d   = 4'd0;
            celeb_d = 8'd0;
            flash_d = 1'b1;
            state_d = CELEBRATE;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q   <= PLAY;
            cnt_q     <= 4'd0;
            celeb_q   <= 8'd0;
            side_q    <= 1'b0;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            flash_q   <= 1'b0;
            rr_q      <= 1'b0;
            go_q      <= 1'b0;
            win_q     <= 1'b0;
        end else if (!Pause) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            celeb_q   <= celeb_d;
            side_q    <= side_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            flash_q   <= flash_d;
            rr_q      <= rr_d;
            go_q      <= go_d;
            win_q     <= win_d;
        end
    end

    assign bus.ScoreL     = score_l_q;
    assign bus.ScoreR     = score_r_q;
    assign bus.GoalFlash  = flash_q;
    assign bus.RoundReset = rr_q;
    assign bus.GameOver   = go_q;
    assign bus.Winner     = win_q;
    assign dbg_state_o    = state_q;
    assign dbg_cnt_o      = cnt_q;

endmodule

// File: tb/tb_goal_score_tracker.sv
// Directed-frame bench for goal_score_tracker: a driver pushes the expected
// post-edge snapshot for each frame and a monitor compares after every edge.
module tb_goal_score_tracker;
  localparam logic [1:0] S_PLAY = 2'd0, S_CONF = 2'd1, S_CELEB = 2'd2, S_OVER = 2'd3;
  localparam int W = 18;

  logic clk;
  logic rst;
  logic pause;
  logic [1:0] dbg_state;
  logic [3:0] dbg_cnt;

  goal_score_tracker_if bus ();

  goal_score_tracker #(.DEBOUNCE(3), .CELEB_FRAMES(120), .WIN_SCORE(5)) dut (
    .frame_clk  (clk),
    .Reset      (rst),
    .Pause      (pause),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state),
    .dbg_cnt_o  (dbg_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        lbl_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;
  int           sl = 0;
  int           sr = 0;

  function automatic logic [W-1:0] mk(input logic [1:0] st, input int cnt, input bit fl,
                                      input bit rr, input bit go, input bit wn);
    mk = {st, 4'(cnt), 4'(sl), 4'(sr), fl, rr, go, wn};
  endfunction

  initial begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    string        l;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        l   = lbl_q.pop_front();
        act = {dbg_state, dbg_cnt, bus.ScoreL, bus.ScoreR, bus.GoalFlash,
               bus.RoundReset, bus.GameOver, bus.Winner};
        tests_run++;
        if (act !== e) begin
          tests_failed++;
          $display("FAIL %s: got st=%0d cnt=%0d L=%0d R=%0d fl=%b rr=%b go=%b w=%b, expected st=%0d cnt=%0d L=%0d R=%0d fl=%b rr=%b go=%b w=%b",
                   l, act[17:16], act[15:12], act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                   e[17:16], e[15:12], e[11:8], e[7:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic frame(input int bx, input int by, input bit p, input bit r,
                       input logic [W-1:0] e, input string lbl);
    @(negedge clk);
    bus.BallX = 10'(bx);
    bus.BallY = 10'(by);
    pause     = p;
    rst       = r;
    exp_q.push_back(e);
    lbl_q.push_back(lbl);
  endtask

  task automatic celebrate(input int n, input int bx, input bit p, input string lbl);
    for (int i = 0; i < n; i++) frame(bx, 420, p, 1'b0, mk(S_CELEB, 0, 1, 0, 0, 0), lbl);
  endtask

  // Full goal: ball held in one goal through debounce and the whole celebration.
  task automatic score_goal(input bit right_goal);
    int bx;
    bx = right_goal ? 600 : 40;
    frame(bx, 420, 0, 0, mk(S_CONF, 1, 0, 0, 0, 0), "goal_c1");
    frame(bx, 420, 0, 0, mk(S_CONF, 2, 0, 0, 0, 0), "goal_c2");
    if (right_goal) sl++; else sr++;
    frame(bx, 420, 0, 0, mk(S_CELEB, 0, 1, 0, 0, 0), "goal_award");
    celebrate(119, bx, 0, "goal_celeb");
    if (sl == 5 || sr == 5)
      frame(bx, 420, 0, 0, mk(S_OVER, 0, 0, 0, 1, sr == 5), "goal_gameover");
    else
      frame(bx, 420, 0, 0, mk(S_PLAY, 0, 0, 1, 0, 0), "goal_roundreset");
  endtask

  initial begin
    rst         = 1'b1;
    pause       = 1'b0;
    bus.BallX   = 10'd320;
    bus.BallY   = 10'd420;
    bus.BallS   = 10'd12;
    bus.GoalLX  = 10'd0;
    bus.GoalLY  = 10'd460;
    bus.GoalLSX = 10'd72;
    bus.GoalLSY = 10'd128;
    bus.GoalRX  = 10'd567;
    bus.GoalRY  = 10'd460;
    bus.GoalRSX = 10'd72;
    bus.GoalRSY = 10'd128;

    frame(320, 420, 0, 1, mk(S_PLAY, 0, 0, 0, 0, 0), "reset");
    frame(320, 420, 0, 1, mk(S_PLAY, 0, 0, 0, 0, 0), "reset_hold");
    frame(320, 420, 0, 0, mk(S_PLAY, 0, 0, 0, 0, 0), "idle");

    // ball in left goal: right player scores on the 3rd edge
    score_goal(1'b0);
    frame(320, 420, 0, 0, mk(S_PLAY, 0, 0, 0, 0, 0), "rr_clears");

    // short stays and side flip never score
    frame(40, 420, 0, 0, mk(S_CONF, 1, 0, 0, 0, 0), "short_c1");
    frame(40, 420, 0, 0, mk(S_CONF, 2, 0, 0, 0, 0), "short_c2");
    frame(320, 420, 0, 0, mk(S_PLAY, 0, 0, 0, 0, 0), "short_leave");
    frame(40, 420, 0, 0, mk(S_CONF, 1, 0, 0, 0, 0), "short2_c1");
    frame(40, 420, 0, 0, mk(S_CONF, 2, 0, 0, 0, 0), "short2_c2");
    frame(320, 420, 0, 0, mk(S_PLAY, 0, 0, 0, 0, 0), "short2_leave");
    frame(40, 420, 0, 0, mk(S_CONF, 1, 0, 0, 0, 0), "flip_c1");
    frame(600, 420, 0, 0, mk(S_PLAY, 0, 0, 0, 0, 0), "flip_abort");
    frame(600, 420, 0, 0, mk(S_CONF, 1, 0, 0, 0, 0), "flip_r_c1");
    frame(320, 420, 0, 0, mk(S_PLAY, 0, 0, 0, 0, 0), "flip_leave");

    // right goal with pauses mid-confirm, mid-celebration and on the pulse
    frame(600, 420, 0, 0, mk(S_CONF, 1, 0, 0, 0, 0), "pz_c1");
    frame(600, 420, 0, 0, mk(S_CONF, 2, 0, 0, 0, 0), "pz_c2");
    for (int i = 0; i < 10; i++)
      frame(320, 420, 1, 0, mk(S_CONF, 2, 0, 0, 0, 0), "pz_confirm_frozen");
    sl++;
    frame(600, 420, 0, 0, mk(S_CELEB, 0, 1, 0, 0, 0), "pz_award");
    celebrate(50, 600, 0, "pz_celeb_a");
    celebrate(10, 600, 1, "pz_celeb_frozen");
    celebrate(69, 600, 0, "pz_celeb_b");
    frame(600, 420, 0, 0, mk(S_PLAY, 0, 0, 1, 0, 0), "pz_roundreset");
    for (int i = 0; i < 3; i++)
      frame(600, 420, 1, 0, mk(S_PLAY, 0, 0, 1, 0, 0), "pz_rr_held");
    frame(600, 420, 0, 0, mk(S_CONF, 1, 0, 0, 0, 0), "pz_rr_clear_count");
    frame(320, 420, 0, 0, mk(S_PLAY, 0, 0, 0, 0, 0), "pz_leave");

    // over the crossbar and straddling the post
    for (int i = 0; i < 5; i++)
      frame(40, 300, 0, 0, mk(S_PLAY, 0, 0, 0, 0, 0), "over_crossbar");
    for (int i = 0; i < 5; i++)
      frame(70, 420, 0, 0, mk(S_PLAY, 0, 0, 0, 0, 0), "on_post");

    // left player to five: the last celebration ends the game
    score_goal(1'b1);
    score_goal(1'b1);
    score_goal(1'b1);
    score_goal(1'b1);
    for (int i = 0; i < 4; i++)
      frame(40, 420, 0, 0, mk(S_OVER, 0, 0, 0, 1, 0), "gameover_frozen_l");
    for (int i = 0; i < 4; i++)
      frame(600, 420, 0, 0, mk(S_OVER, 0, 0, 0, 1, 0), "gameover_frozen_r");

    // reset (with pause held) clears game over; reset mid-celebration aborts it
    sl = 0;
    sr = 0;
    frame(320, 420, 1, 1, mk(S_PLAY, 0, 0, 0, 0, 0), "reset_over_pause");
    frame(40, 420, 0, 0, mk(S_CONF, 1, 0, 0, 0, 0), "rc_c1");
    frame(40, 420, 0, 0, mk(S_CONF, 2, 0, 0, 0, 0), "rc_c2");
    sr++;
    frame(40, 420, 0, 0, mk(S_CELEB, 0, 1, 0, 0, 0), "rc_award");
    celebrate(30, 40, 0, "rc_celeb");
    sr = 0;
    frame(320, 420, 0, 1, mk(S_PLAY, 0, 0, 0, 0, 0), "rc_reset");
    for (int i = 0; i < 125; i++)
      frame(320, 420, 0, 0, mk(S_PLAY, 0, 0, 0, 0, 0), "rc_no_pulse");

    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/goal_score_tracker.md
Name: goal_score_tracker

Overview:
Consumes the goal-rectangle outputs of the two goal-post instances (left, right) and the ball position/size from the ball stage, once per frame. Detects a goal with frame-count debounce, keeps both scores, and runs a celebration hold. Issues a one-frame round-reset pulse to re-seat ball and players, and latches game-over when a score reaches the win value. Sits between the object-position stages and the HUD/color mapper.

Parameters:
DEBOUNCE, 3, consecutive in-goal frames required to award a goal (1..15)
CELEB_FRAMES, 120, frames GoalFlash is held after a goal (1..255)
WIN_SCORE, 5, score that ends the game (1..15)

Ports:
frame_clk  in  1  frame clock (one edge per video frame)
Reset  in  1  synchronous, active-high reset
Pause  in  1  freezes state, counters and outputs while high
BallX  in  10  ball center X, pixels
BallY  in  10  ball center Y, pixels
BallS  in  10  ball radius, pixels
GoalLX, GoalLY  in  10 each  left goal: left edge X, bottom edge Y
GoalLSX, GoalLSY  in  10 each  left goal width, height
GoalRX, GoalRY  in  10 each  right goal: left edge X, bottom edge Y
GoalRSX, GoalRSY  in  10 each  right goal width, height
ScoreL  out  4  left player score
ScoreR  out  4  right player score
GoalFlash  out  1  high during celebration
RoundReset  out  1  one-frame pulse ending a non-final celebration
GameOver  out  1  sticky once a score reaches WIN_SCORE
Winner  out  1  0 = left player, 1 = right player; valid when GameOver=1

Behaviour:
- Reset (sync, highest priority, overrides Pause): state=PLAY, cnt=0, celeb=0, ScoreL=ScoreR=0, GoalFlash=0, RoundReset=0, GameOver=0, Winner=0. Reset in any state, including mid-celebration, aborts it with no pulse.
- Goal geometry: vertical span is [GoalY-GoalSY, GoalY].
- All arithmetic is 11-bit unsigned (zero-extended inputs). X-BallS and Y-BallS underflow clamps to 0.
- InL = (BallX+BallS < GoalLX+GoalLSX) && (BallY-BallS >= GoalLY-GoalLSY) && (BallY+BallS <= GoalLY).
- InR = (BallX-BallS >= GoalRX) && the same vertical test against the right goal.
- If InL and InR are both true, InL wins.
- InL awards the goal to the right player (ScoreR). InR awards it to the left player (ScoreL).
- Pause=1: no register changes except Reset. A RoundReset already high stays high until the first unpaused edge, which clears it.
- FSM, evaluated every unpaused frame_clk edge:
  - PLAY: if InL|InR, record side, cnt=1, go to CONFIRM. With DEBOUNCE=1, award immediately instead (see award).
  - CONFIRM:
    - Same-side in-goal and cnt==DEBOUNCE-1: award.
    - Same-side in-goal otherwise: cnt++.
    - Not in goal, or side flipped: cnt=0, go to PLAY.
  - award: increment the recorded side's score (saturate at 15), celeb=0, GoalFlash=1, go to CELEBRATE. The award edge is the DEBOUNCE-th consecutive qualifying edge.
  - CELEBRATE: ball ignored; celeb++.
    - When celeb==CELEB_FRAMES-1 and neither score ==WIN_SCORE: GoalFlash=0, RoundReset=1 for exactly one edge, go to PLAY.
    - When celeb==CELEB_FRAMES-1 and a score ==WIN_SCORE: GoalFlash=0, GameOver=1, Winner=(ScoreR==WIN_SCORE), go to GAME_OVER. No RoundReset.
  - GAME_OVER: absorbing until Reset; scores frozen; ball ignored.
- RoundReset is registered and self-clears on the next unpaused edge.
- Scores change only on the award edge.

Test Plan:
- Goals L=(X0,Y460,SX72,SY128), R=(X567,Y460,SX72,SY128). Ball (40,420,S12) held 3 frames -> ScoreR 0->1 on 3rd edge, GoalFlash=1 same edge, ScoreL=0.
- Ball (40,420,S12) for 2 frames, then (320,420) -> no score, state back to PLAY, cnt=0. Two more in-goal frames then leave -> still no score.
- Ball (600,420,S12) 3 frames, then 120 frames elapse -> ScoreL=1. GoalFlash high for 120 edges. RoundReset high exactly one edge after the 120th. Next in-goal frames are counted normally.
- Ball (40,300,S12) (top 288 < 332, over crossbar) and ball (70,420,S12) (82 >= 72, straddling post) -> never scores.
- Drive ScoreL to 4, then award left -> ScoreL=5. After celebration: GameOver=1, Winner=0, RoundReset never pulses. Further in-goal balls do not change scores.
- Pause=1 for 10 frames mid-CONFIRM and mid-CELEBRATE -> counters resume exactly where frozen. Reset mid-CELEBRATE -> all outputs 0 next edge, no RoundReset.
